// File: rtl/data_memory_bridge_pkg.sv
// rtl/data_memory_bridge_pkg.sv - shared state encodings and constants for the data-memory bridge
package data_memory_bridge_pkg;

  typedef enum logic [1:0] {
    BRIDGE_IDLE = 2'd0,
    BRIDGE_BUSY = 2'd1,
    BRIDGE_DONE = 2'd2
  } bridge_state_t;

  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [3:0] SELECT_ALL = 4'b1111;

  // Bus addresses are word granular; the low two byte-offset bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] byte_address);
    return byte_address & ~32'd3;
  endfunction

endpackage

// File: rtl/data_memory_bridge_if.sv
// rtl/data_memory_bridge_if.sv - req/ready data-memory bus between the bridge (master) and memory (slave)
interface data_memory_bridge_if;

  logic        bus_request;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [3:0]  bus_select;
  logic [31:0] bus_write_data;
  logic        bus_ready;
  logic [31:0] bus_read_data;
  logic        bus_error;

  modport master (
    output bus_request,
    output bus_write,
    output bus_address,
    output bus_select,
    output bus_write_data,
    output bus_error,
    input  bus_ready,
    input  bus_read_data
  );

  modport slave (
    input  bus_request,
    input  bus_write,
    input  bus_address,
    input  bus_select,
    input  bus_write_data,
    input  bus_error,
    output bus_ready,
    output bus_read_data
  );

endinterface

// File: rtl/data_memory_bridge_bus_timeout_counter.sv
// rtl/data_memory_bridge_bus_timeout_counter.sv - counts bus wait cycles and flags when the limit is reached
module bus_timeout_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // Counts the current waiting cycle too, so a limit of N aborts in the Nth wait cycle.
  assign expired = enable && (({1'b0, count} + 17'd1) == {1'b0, limit});

endmodule

// File: rtl/data_memory_bridge.sv
// rtl/data_memory_bridge.sv - stalls the access stage around a req/ready data-memory transaction
// Optional bus wait abort is compiled in with DATA_BUS_TIMEOUT_EN.
module data_memory_bridge
  import data_memory_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        memory_read_enable,
  input  logic [31:0]                 memory_read_address,
  output logic [31:0]                 memory_read_data,
  input  logic                        memory_write_enable,
  input  logic [31:0]                 memory_write_address,
  input  logic [3:0]                  memory_write_select,
  input  logic [31:0]                 memory_write_data,
  output logic                        stall_request,
  data_memory_bridge_if.master        bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  bridge_state_t state;
  logic          bus_request_q;
  logic          bus_write_q;
  logic [31:0]   bus_address_q;
  logic [3:0]    bus_select_q;
  logic [31:0]   bus_write_data_q;
  logic [31:0]   read_word;
  logic          access_request;
  logic          timeout_expired;

  assign access_request = (memory_read_enable == READ_ENABLE) ||
                          (memory_write_enable == WRITE_ENABLE);

`ifdef DATA_BUS_TIMEOUT_EN
  logic bus_error_q;
  logic wait_cycle;
  logic busy_entry;

  assign wait_cycle = (state == BRIDGE_BUSY) && !bus.bus_ready;
  assign busy_entry = (state == BRIDGE_IDLE) && access_request;

  bus_timeout_counter u_timeout (
    .clock   (clock),
    .reset   (reset),
    .enable  (wait_cycle),
    .clear   (busy_entry),
    .limit   (16'(TIMEOUT_CYCLES)),
    .expired (timeout_expired)
  );

  assign bus.bus_error = bus_error_q;
`else
  assign timeout_expired = 1'b0;
  assign bus.bus_error   = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= BRIDGE_IDLE;
      bus_request_q    <= 1'b0;
      bus_write_q      <= 1'b0;
      bus_address_q    <= 32'd0;
      bus_select_q     <= 4'd0;
      bus_write_data_q <= 32'd0;
      read_word        <= 32'd0;
`ifdef DATA_BUS_TIMEOUT_EN
      bus_error_q      <= 1'b0;
`endif
    end else begin
`ifdef DATA_BUS_TIMEOUT_EN
      bus_error_q <= 1'b0;
`endif
      case (state)
        BRIDGE_IDLE: begin
          // Write wins when both enables are raised together.
          if (memory_write_enable == WRITE_ENABLE) begin
            bus_write_q      <= 1'b1;
            bus_address_q    <= word_align(memory_write_address);
            bus_select_q     <= memory_write_select;
            bus_write_data_q <= memory_write_data;
            bus_request_q    <= 1'b1;
            state            <= BRIDGE_BUSY;
          end else if (memory_read_enable == READ_ENABLE) begin
            bus_write_q      <= 1'b0;
            bus_address_q    <= word_align(memory_read_address);
            bus_select_q     <= SELECT_ALL;
            bus_write_data_q <= 32'd0;
            bus_request_q    <= 1'b1;
            state            <= BRIDGE_BUSY;
          end
        end
        BRIDGE_BUSY: begin
          if (bus.bus_ready) begin
            read_word     <= bus_write_q ? 32'd0 : bus.bus_read_data;
            bus_request_q <= 1'b0;
            state         <= BRIDGE_DONE;
          end else if (timeout_expired) begin
            read_word     <= 32'hFFFF_FFFF;
            bus_request_q <= 1'b0;
`ifdef DATA_BUS_TIMEOUT_EN
            bus_error_q   <= 1'b1;
`endif
            state         <= BRIDGE_DONE;
          end
        end
        BRIDGE_DONE: begin
          // The stage still holds the completed request here; it must not start a new access.
          state <= BRIDGE_IDLE;
        end
        default: begin
          state         <= BRIDGE_IDLE;
          bus_request_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall_request    = 1'b0;
    memory_read_data = 32'd0;
    case (state)
      BRIDGE_IDLE: stall_request    = access_request;
      BRIDGE_BUSY: stall_request    = 1'b1;
      BRIDGE_DONE: memory_read_data = read_word;
      default:     stall_request    = 1'b0;
    endcase
  end

  assign bus.bus_request    = bus_request_q;
  assign bus.bus_write      = bus_write_q;
  assign bus.bus_address    = bus_address_q;
  assign bus.bus_select     = bus_select_q;
  assign bus.bus_write_data = bus_write_data_q;

endmodule

// File: tb/tb_data_memory_bridge.sv
// tb/tb_data_memory_bridge.sv - directed self-checking bench for data_memory_bridge
module tb_data_memory_bridge;

  logic        clock;
  logic        reset;
  logic        memory_read_enable;
  logic [31:0] memory_read_address;
  logic [31:0] memory_read_data;
  logic        memory_write_enable;
  logic [31:0] memory_write_address;
  logic [3:0]  memory_write_select;
  logic [31:0] memory_write_data;
  logic        stall_request;

  int n_cmp;
  int n_fail;

  data_memory_bridge_if bus_if ();

  data_memory_bridge #(.TIMEOUT_CYCLES(3)) dut (
    .clock                (clock),
    .reset                (reset),
    .memory_read_enable   (memory_read_enable),
    .memory_read_address  (memory_read_address),
    .memory_read_data     (memory_read_data),
    .memory_write_enable  (memory_write_enable),
    .memory_write_address (memory_write_address),
    .memory_write_select  (memory_write_select),
    .memory_write_data    (memory_write_data),
    .stall_request        (stall_request),
    .bus                  (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset;
    reset = 1'b0;
    memory_read_enable = 1'b0;
    memory_read_address = 32'd0;
    memory_write_enable = 1'b0;
    memory_write_address = 32'd0;
    memory_write_select = 4'd0;
    memory_write_data = 32'd0;
    bus_if.bus_ready = 1'b0;
    bus_if.bus_read_data = 32'd0;
    @(negedge clock);
    @(negedge clock);
    #1;
    n_cmp++; if (bus_if.bus_request !== 1'b0) begin n_fail++; $display("FAIL rst_req got %0b want 0", bus_if.bus_request); end
    n_cmp++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0b want 0", stall_request); end
    n_cmp++; if (bus_if.bus_address !== 32'd0) begin n_fail++; $display("FAIL rst_addr got %h want 0", bus_if.bus_address); end
    n_cmp++; if (bus_if.bus_select !== 4'd0) begin n_fail++; $display("FAIL rst_sel got %b want 0", bus_if.bus_select); end
    n_cmp++; if (bus_if.bus_write !== 1'b0) begin n_fail++; $display("FAIL rst_write got %0b want 0", bus_if.bus_write); end
    n_cmp++; if (memory_read_data !== 32'd0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", memory_read_data); end
    n_cmp++; if (bus_if.bus_error !== 1'b0) begin n_fail++; $display("FAIL rst_err got %0b want 0", bus_if.bus_error); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_read;
    @(negedge clock);
    memory_read_enable = 1'b1;
    memory_read_address = 32'h0000_1006;
    #1;
    n_cmp++; if (stall_request !== 1'b1) begin n_fail++; $display("FAIL rd_idle_stall got %0b want 1", stall_request); end
    n_cmp++; if (bus_if.bus_request !== 1'b0) begin n_fail++; $display("FAIL rd_idle_req got %0b want 0", bus_if.bus_request); end
    @(negedge clock);
    bus_if.bus_ready = 1'b1;
    bus_if.bus_read_data = 32'hA1B2_C3D4;
    #1;
    n_cmp++; if (bus_if.bus_request !== 1'b1) begin n_fail++; $display("FAIL rd_busy_req got %0b want 1", bus_if.bus_request); end
    n_cmp++; if (bus_if.bus_address !== 32'h0000_1004) begin n_fail++; $display("FAIL rd_addr got %h want 00001004", bus_if.bus_address); end
    n_cmp++; if (bus_if.bus_select !== 4'b1111) begin n_fail++; $display("FAIL rd_sel got %b want 1111", bus_if.bus_select); end
    n_cmp++; if (bus_if.bus_write !== 1'b0) begin n_fail++; $display("FAIL rd_write got %0b want 0", bus_if.bus_write); end
    n_cmp++; if (stall_request !== 1'b1) begin n_fail++; $display("FAIL rd_busy_stall got %0b want 1", stall_request); end
    n_cmp++; if (memory_read_data !== 32'd0) begin n_fail++; $display("FAIL rd_busy_rdata got %h want 0", memory_read_data); end
    @(negedge clock);
    bus_if.bus_ready = 1'b0;
    bus_if.bus_read_data = 32'd0;
    #1;
    n_cmp++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL rd_done_stall got %0b want 0", stall_request); end
    n_cmp++; if (bus_if.bus_request !== 1'b0) begin n_fail++; $display("FAIL rd_done_req got %0b want 0", bus_if.bus_request); end
    n_cmp++; if (memory_read_data !== 32'hA1B2_C3D4) begin n_fail++; $display("FAIL rd_done_rdata got %h want a1b2c3d4", memory_read_data); end
    @(negedge clock);
    memory_read_enable = 1'b0;
    memory_read_address = 32'd0;
    #1;
    n_cmp++; if (memory_read_data !== 32'd0) begin n_fail++; $display("FAIL rd_after_rdata got %h want 0", memory_read_data); end
    n_cmp++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL rd_after_stall got %0b want 0", stall_request); end
  endtask

  task automatic test_write;
    int stalls;
    stalls = 0;
    @(negedge clock);
    memory_write_enable = 1'b1;
    memory_write_address = 32'h0000_0020;
    memory_write_select = 4'b0011;
    memory_write_data = 32'h5555_5555;
    #1;
    if (stall_request === 1'b1) stalls++;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      bus_if.bus_ready = (i == 4);
      bus_if.bus_read_data = 32'h1234_5678;
      #1;
      if (stall_request === 1'b1) stalls++;
      n_cmp++; if (bus_if.bus_request !== 1'b1) begin n_fail++; $display("FAIL wr_req[%0d] got %0b want 1", i, bus_if.bus_request); end
      n_cmp++; if (bus_if.bus_address !== 32'h0000_0020) begin n_fail++; $display("FAIL wr_addr[%0d] got %h want 00000020", i, bus_if.bus_address); end
      n_cmp++; if (bus_if.bus_select !== 4'b0011) begin n_fail++; $display("FAIL wr_sel[%0d] got %b want 0011", i, bus_if.bus_select); end
      n_cmp++; if (bus_if.bus_write !== 1'b1) begin n_fail++; $display("FAIL wr_write[%0d] got %0b want 1", i, bus_if.bus_write); end
      n_cmp++; if (bus_if.bus_write_data !== 32'h5555_5555) begin n_fail++; $display("FAIL wr_wdata[%0d] got %h want 55555555", i, bus_if.bus_write_data); end
      n_cmp++; if (memory_read_data !== 32'd0) begin n_fail++; $display("FAIL wr_rdata[%0d] got %h want 0", i, memory_read_data); end
    end
    @(negedge clock);
    bus_if.bus_ready = 1'b0;
    bus_if.bus_read_data = 32'd0;
    #1;
    if (stall_request === 1'b1) stalls++;
    n_cmp++; if (memory_read_data !== 32'd0) begin n_fail++; $display("FAIL wr_done_rdata got %h want 0", memory_read_data); end
    n_cmp++; if (stalls !== 5) begin n_fail++; $display("FAIL wr_stall_cycles got %0d want 5", stalls); end
    @(negedge clock);
    memory_write_enable = 1'b0;
    memory_write_select = 4'd0;
  endtask

  task automatic test_both_enables;
    @(negedge clock);
    memory_read_enable = 1'b1;
    memory_read_address = 32'h0000_0100;
    memory_write_enable = 1'b1;
    memory_write_address = 32'h0000_0040;
    memory_write_select = 4'b0100;
    memory_write_data = 32'h0077_0000;
    @(negedge clock);
    bus_if.bus_ready = 1'b1;
    bus_if.bus_read_data = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (bus_if.bus_write !== 1'b1) begin n_fail++; $display("FAIL both_write got %0b want 1", bus_if.bus_write); end
    n_cmp++; if (bus_if.bus_address !== 32'h0000_0040) begin n_fail++; $display("FAIL both_addr got %h want 00000040", bus_if.bus_address); end
    n_cmp++; if (bus_if.bus_select !== 4'b0100) begin n_fail++; $display("FAIL both_sel got %b want 0100", bus_if.bus_select); end
    @(negedge clock);
    bus_if.bus_ready = 1'b0;
    #1;
    n_cmp++; if (memory_read_data !== 32'd0) begin n_fail++; $display("FAIL both_done_rdata got %h want 0", memory_read_data); end
    @(negedge clock);
    memory_read_enable = 1'b0;
    memory_write_enable = 1'b0;
    bus_if.bus_read_data = 32'd0;
  endtask

  task automatic test_reset_mid_busy;
    @(negedge clock);
    memory_read_enable = 1'b1;
    memory_read_address = 32'h0000_0080;
    @(negedge clock);
    @(negedge clock);
    #1;
    n_cmp++; if (bus_if.bus_request !== 1'b1) begin n_fail++; $display("FAIL rm_busy2_req got %0b want 1", bus_if.bus_request); end
    reset = 1'b0;
    memory_read_enable = 1'b0;
    #1;
    n_cmp++; if (bus_if.bus_request !== 1'b0) begin n_fail++; $display("FAIL rm_req got %0b want 0", bus_if.bus_request); end
    n_cmp++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL rm_stall got %0b want 0", stall_request); end
    @(negedge clock);
    reset = 1'b1;
    memory_read_enable = 1'b1;
    memory_read_address = 32'h0000_0084;
    #1;
    n_cmp++; if (stall_request !== 1'b1) begin n_fail++; $display("FAIL rm_new_stall got %0b want 1", stall_request); end
    @(negedge clock);
    bus_if.bus_ready = 1'b1;
    bus_if.bus_read_data = 32'hCAFE_F00D;
    #1;
    n_cmp++; if (bus_if.bus_address !== 32'h0000_0084) begin n_fail++; $display("FAIL rm_new_addr got %h want 00000084", bus_if.bus_address); end
    @(negedge clock);
    bus_if.bus_ready = 1'b0;
    bus_if.bus_read_data = 32'd0;
    #1;
    n_cmp++; if (memory_read_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rm_new_rdata got %h want cafef00d", memory_read_data); end
    @(negedge clock);
    memory_read_enable = 1'b0;
  endtask

`ifdef DATA_BUS_TIMEOUT_EN
  task automatic test_timeout;
    @(negedge clock);
    memory_read_enable = 1'b1;
    memory_read_address = 32'h0000_0300;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      #1;
      n_cmp++; if (bus_if.bus_request !== 1'b1) begin n_fail++; $display("FAIL to_req[%0d] got %0b want 1", i, bus_if.bus_request); end
      n_cmp++; if (bus_if.bus_error !== 1'b0) begin n_fail++; $display("FAIL to_err_early[%0d] got %0b want 0", i, bus_if.bus_error); end
    end
    @(negedge clock);
    #1;
    n_cmp++; if (bus_if.bus_error !== 1'b1) begin n_fail++; $display("FAIL to_err got %0b want 1", bus_if.bus_error); end
    n_cmp++; if (bus_if.bus_request !== 1'b0) begin n_fail++; $display("FAIL to_req_drop got %0b want 0", bus_if.bus_request); end
    n_cmp++; if (memory_read_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL to_rdata got %h want ffffffff", memory_read_data); end
    n_cmp++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL to_stall got %0b want 0", stall_request); end
    @(negedge clock);
    memory_read_enable = 1'b0;
    #1;
    n_cmp++; if (bus_if.bus_error !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse got %0b want 0", bus_if.bus_error); end
    @(negedge clock);
    memory_read_enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      bus_if.bus_ready = (i == 3);
      bus_if.bus_read_data = 32'h600D_F00D;
    end
    @(negedge clock);
    bus_if.bus_ready = 1'b0;
    #1;
    n_cmp++; if (bus_if.bus_error !== 1'b0) begin n_fail++; $display("FAIL to_race_err got %0b want 0", bus_if.bus_error); end
    n_cmp++; if (memory_read_data !== 32'h600D_F00D) begin n_fail++; $display("FAIL to_race_rdata got %h want 600df00d", memory_read_data); end
    @(negedge clock);
    memory_read_enable = 1'b0;
    bus_if.bus_read_data = 32'd0;
  endtask
`else
  task automatic test_no_timeout;
    @(negedge clock);
    memory_read_enable = 1'b1;
    memory_read_address = 32'h0000_0300;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      #1;
      n_cmp++; if (bus_if.bus_request !== 1'b1 || stall_request !== 1'b1 || bus_if.bus_error !== 1'b0) begin
        n_fail++; $display("FAIL nt_wait[%0d] got req=%0b stall=%0b err=%0b want 1 1 0", i, bus_if.bus_request, stall_request, bus_if.bus_error);
      end
    end
    bus_if.bus_ready = 1'b1;
    bus_if.bus_read_data = 32'h0BAD_CAFE;
    @(negedge clock);
    bus_if.bus_ready = 1'b0;
    #1;
    n_cmp++; if (memory_read_data !== 32'h0BAD_CAFE) begin n_fail++; $display("FAIL nt_rdata got %h want 0badcafe", memory_read_data); end
    @(negedge clock);
    memory_read_enable = 1'b0;
    bus_if.bus_read_data = 32'd0;
  endtask
`endif

  task automatic test_back_to_back;
    logic [6:0]  req_hist;
    logic [6:0]  req_want;
    logic [31:0] rd_hist [7];
    req_want = 7'b0010010;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      memory_read_enable = (c < 6);
      memory_read_address = (c < 3) ? 32'h0000_0200 : 32'h0000_0300;
      #1;
      req_hist[c] = bus_if.bus_request;
      rd_hist[c] = memory_read_data;
      bus_if.bus_ready = bus_if.bus_request;
      bus_if.bus_read_data = !bus_if.bus_request ? 32'd0 :
                             (bus_if.bus_address == 32'h0000_0200) ? 32'h1111_1111 : 32'h2222_2222;
    end
    bus_if.bus_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      n_cmp++; if (req_hist[c] !== req_want[c]) begin n_fail++; $display("FAIL b2b_req[%0d] got %0b want %0b", c, req_hist[c], req_want[c]); end
    end
    n_cmp++; if (rd_hist[2] !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_rdata_a got %h want 11111111", rd_hist[2]); end
    n_cmp++; if (rd_hist[5] !== 32'h2222_2222) begin n_fail++; $display("FAIL b2b_rdata_b got %h want 22222222", rd_hist[5]); end
    n_cmp++; if (rd_hist[4] !== 32'd0) begin n_fail++; $display("FAIL b2b_rdata_busy got %h want 0", rd_hist[4]); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_read();
    test_write();
    test_both_enables();
    test_reset_mid_busy();
`ifdef DATA_BUS_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_bridge.md
# data_memory_bridge

Sequential bridge between the memory-access pipeline stage and the data-memory bus. It captures the stage's single-cycle read or write request and drives a req/ready bus handshake. It stalls the pipeline until the bus completes, then presents the returned word to the stage for exactly one un-stalled cycle. The access stage therefore stays purely combinational while the data memory may take any number of cycles.

## Interface
- TIMEOUT_CYCLES, 255: bus wait limit in cycles; used only when the timeout feature is compiled in; legal range 1..65535.
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- memory_read_enable  in  1  read request from the access stage.
- memory_read_address  in  32  byte address of the read.
- memory_read_data  out  32  word returned to the access stage.
- memory_write_enable  in  1  write request from the access stage.
- memory_write_address  in  32  byte address of the write.
- memory_write_select  in  4  byte-lane enables; bit 3 = bits 31:24.
- memory_write_data  in  32  lane-replicated write data.
- stall_request  out  1  holds every pipeline register upstream of writeback.
- bus_request  out  1  transaction valid.
- bus_write  out  1  1 = write, 0 = read.
- bus_address  out  32  word-aligned address, bits 1:0 = 00.
- bus_select  out  4  byte lanes; 4'b1111 for reads.
- bus_write_data  out  32  write data.
- bus_ready  in  1  completion strobe from memory.
- bus_read_data  in  32  read word; valid when bus_ready = 1.
- bus_error  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - If either enable is 1, stall_request = 1 combinationally in the same cycle.
  - Capture address (bits 1:0 cleared), select and data into the bus registers.
  - Next state is BUSY.
- Simultaneous read and write enables: the write wins; the read data returned is 0.
- BUSY:
  - bus_request = 1 and stall_request = 1.
  - bus outputs are held constant.
  - When bus_ready is sampled 1: latch bus_read_data (reads only; writes latch 0), drop bus_request, go to DONE.
- DONE:
  - stall_request = 0.
  - memory_read_data = the latched word; the access stage result is captured downstream this cycle.
  - Next state is IDLE unconditionally. The request seen in DONE is the old, still-held one and is ignored.
- memory_read_data is 0 in IDLE and BUSY.
- bus_ready while in IDLE or DONE is ignored.
- Stage inputs are guaranteed stable while stall_request = 1; the bridge does not re-sample them in BUSY.
- Reset values: state IDLE; all outputs 0; bus registers 0; latched data 0; timeout counter 0.
- Reset asserted mid-BUSY: bus_request drops asynchronously and the transaction is abandoned. Memory must tolerate a dropped request.

## Timing
- Minimum occupancy is 3 cycles: IDLE (stall), BUSY with bus_ready = 1, DONE. That is 2 stall cycles.
- Each additional cycle without bus_ready adds one stall cycle.
- Back-to-back accesses: DONE→IDLE→BUSY. Each access costs at least 3 cycles and there is no overlap.
- bus_* outputs are registered. stall_request and memory_read_data are decoded from registered state plus the two enables only.

## Configuration
- DATA_BUS_TIMEOUT_EN defined:
  - A 16-bit counter clears on BUSY entry and increments each BUSY cycle without bus_ready.
  - When the count equals TIMEOUT_CYCLES, drop bus_request, pulse bus_error for one cycle, and go to DONE with latched data 32'hFFFF_FFFF.
  - bus_ready in that same cycle takes priority: normal completion, no error.
- DATA_BUS_TIMEOUT_EN undefined: BUSY waits indefinitely; bus_error is tied 0; no counter is instantiated.

## Structure
- Shared defines/package holds:
  - state encodings: BRIDGE_IDLE, BRIDGE_BUSY, BRIDGE_DONE;
  - READ_ENABLE/READ_DISABLE and WRITE_ENABLE/WRITE_DISABLE;
  - SELECT_ALL = 4'b1111.
- One sub-module, bus_timeout_counter (enable, clear, limit → expired). It is instantiated only under DATA_BUS_TIMEOUT_EN.

## Test plan
- Read 0x0000_1006, bus_ready 1 cycle after request, bus_read_data 0xA1B2C3D4 → bus_address 0x0000_1004, bus_select 1111, bus_write 0; stall 2 cycles; memory_read_data 0xA1B2C3D4 only in DONE.
- Write 0x20 select 0011 data 0x5555_5555, ready after 4 BUSY cycles → bus held constant 4 cycles, stall 5 cycles, memory_read_data stays 0.
- Both enables high, address 0x40 → bus_write 1; DONE returns 0.
- Reset pulled low in 2nd BUSY cycle → bus_request and stall_request 0 immediately; after release, a new read completes normally.
- With DATA_BUS_TIMEOUT_EN and TIMEOUT_CYCLES = 3, ready never asserted → abort after 3 BUSY cycles, bus_error 1 for one cycle, memory_read_data 0xFFFF_FFFF. Ready on the 3rd BUSY cycle instead → normal completion, bus_error 0.
- Two reads back-to-back, ready immediate → request pulses separated by exactly 2 cycles; each DONE returns its own data.
